idli_uart_tx_m: RTL and testbench

Parametrised UART transmitter for the idli core. It replaces the fixed 8N1, one-clock-per-bit, unbuffered TX path. Bytes arrive from the core as two 4b SQI nibbles and are packed into a byte FIFO. A serialiser with a baud-rate divider, optional parity and a configurable stop-bit count drives the line. Frames are sent back-to-back while the FIFO holds data.

---
 rtl/idli_pkg.sv | 18 +
 rtl/idli_uart_fifo_m.sv | 50 +++++
 rtl/idli_uart_tx_m.sv | 167 ++++++++++++++++
 tb/tb_idli_uart_tx_m.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types for the idli core: SQI nibble and UART TX serialiser states.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [2:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_START  = 3'd1,
    UART_TX_DATA   = 3'd2,
    UART_TX_PARITY = 3'd3,
    UART_TX_STOP   = 3'd4
  } uart_tx_state_t;

  function automatic logic uart_parity(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/idli_uart_fifo_m.sv
// Generic first-word-fall-through FIFO; shared by the UART TX and RX paths.
// Pointers carry one extra MSB so full and empty are distinguishable.
module idli_uart_fifo_m #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_q[AW-1:0]];
  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o   = wr_q - rd_q;

endmodule

// File: rtl/idli_uart_tx_m.sv
// UART transmitter: packs SQI nibbles into a byte FIFO and serialises frames
// with a baud divider, optional parity and 1 or 2 stop bits.
module idli_uart_tx_m
  import idli_pkg::*;
#(
  parameter int CLK_PER_BIT = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0
) (
  input  logic                          i_uart_gck,
  input  logic                          i_uart_rst_n,
  input  sqi_data_t                     i_uart_tx,
  input  logic                          i_uart_tx_vld,
  output logic                          o_uart_tx_acp,
  output logic                          o_uart_tx,
  output logic                          o_uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_uart_tx_level
);

  localparam int            BW        = $clog2(CLK_PER_BIT) + 1;
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = 1'(PARITY_ODD);

  // Nibble assembler
  sqi_data_t lo_q;
  logic      half_q;
  logic      xfer;
  logic      push;

  logic       fifo_full, fifo_empty, pop;
  logic [7:0] pop_dat;

  assign o_uart_tx_acp = !fifo_full;
  assign xfer          = i_uart_tx_vld && o_uart_tx_acp;
  assign push          = xfer && half_q;

  always_ff @(posedge i_uart_gck or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      lo_q   <= '0;
      half_q <= 1'b0;
    end else if (xfer) begin
      if (!half_q) lo_q <= i_uart_tx;
      half_q <= !half_q;
    end
  end

  idli_uart_fifo_m #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (i_uart_gck),
    .rst_n_i    (i_uart_rst_n),
    .push_i     (push),
    .push_dat_i ({i_uart_tx, lo_q}),
    .pop_i      (pop),
    .pop_dat_o  (pop_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (o_uart_tx_level)
  );

  // Serialiser
  uart_tx_state_t state_q, state_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           par_q, par_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic           stop_idx_q, stop_idx_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic           tx_q, tx_d;
  logic           bit_end;

  assign bit_end = (baud_q == '0);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    baud_d     = bit_end ? BAUD_LOAD : baud_q - 1'b1;
    pop        = 1'b0;

    case (state_q)
      UART_TX_IDLE: begin
        baud_d = BAUD_LOAD;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = pop_dat;
          par_d   = uart_parity(pop_dat, PAR_ODD);
          state_d = UART_TX_START;
        end
      end
      UART_TX_START: begin
        if (bit_end) begin
          state_d   = UART_TX_DATA;
          bit_idx_d = 3'd0;
        end
      end
      UART_TX_DATA: begin
        if (bit_end) begin
          shreg_d   = shreg_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d    = (PARITY_EN != 0) ? UART_TX_PARITY : UART_TX_STOP;
            stop_idx_d = 1'b0;
          end
        end
      end
      UART_TX_PARITY: begin
        if (bit_end) begin
          state_d    = UART_TX_STOP;
          stop_idx_d = 1'b0;
        end
      end
      UART_TX_STOP: begin
        if (bit_end) begin
          if (stop_idx_q != STOP_LAST) begin
            stop_idx_d = 1'b1;
          end else if (!fifo_empty) begin
            // Chain straight into the next start bit to keep frames back-to-back
            pop     = 1'b1;
            shreg_d = pop_dat;
            par_d   = uart_parity(pop_dat, PAR_ODD);
            state_d = UART_TX_START;
          end else begin
            state_d = UART_TX_IDLE;
          end
        end
      end
      default: state_d = UART_TX_IDLE;
    endcase

    case (state_d)
      UART_TX_START:  tx_d = 1'b0;
      UART_TX_DATA:   tx_d = shreg_d[0];
      UART_TX_PARITY: tx_d = par_d;
      default:        tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_uart_gck or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      state_q    <= UART_TX_IDLE;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
    end
  end

  assign o_uart_tx      = tx_q;
  assign o_uart_tx_busy = (state_q != UART_TX_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_idli_uart_tx_m.sv
// Directed bench for idli_uart_tx_m: three configurations (8N1 /4, 8E2 /1, 8O1 /1)
// driven from per-instance nibble queues, line checked bit-by-bit per cycle.
module tb_idli_uart_tx_m;
  import idli_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  sqi_data_t  nib [3];
  logic       vld [3];
  logic       acp [3];
  logic       tx [3];
  logic       busy [3];
  logic [2:0] lvl [3];

  sqi_data_t  nq [3][$];
  int         n_acc [3];
  int         last_acc [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A: 8N1, 4 clocks per bit
  idli_uart_tx_m #(.CLK_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_a (
    .i_uart_gck(clk), .i_uart_rst_n(rst_n), .i_uart_tx(nib[0]), .i_uart_tx_vld(vld[0]),
    .o_uart_tx_acp(acp[0]), .o_uart_tx(tx[0]), .o_uart_tx_busy(busy[0]), .o_uart_tx_level(lvl[0]));
  // B: 8E2, 1 clock per bit
  idli_uart_tx_m #(.CLK_PER_BIT(1), .FIFO_DEPTH(4), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .i_uart_gck(clk), .i_uart_rst_n(rst_n), .i_uart_tx(nib[1]), .i_uart_tx_vld(vld[1]),
    .o_uart_tx_acp(acp[1]), .o_uart_tx(tx[1]), .o_uart_tx_busy(busy[1]), .o_uart_tx_level(lvl[1]));
  // C: 8O1, 1 clock per bit
  idli_uart_tx_m #(.CLK_PER_BIT(1), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u_c (
    .i_uart_gck(clk), .i_uart_rst_n(rst_n), .i_uart_tx(nib[2]), .i_uart_tx_vld(vld[2]),
    .o_uart_tx_acp(acp[2]), .o_uart_tx(tx[2]), .o_uart_tx_busy(busy[2]), .o_uart_tx_level(lvl[2]));

  // Nibble driver: handshake observed mid-cycle, next nibble presented just after the edge.
  initial begin
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; nib[i] = '0; n_acc[i] = 0; last_acc[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst_n && vld[i] && acp[i]) begin
          void'(nq[i].pop_front());
          n_acc[i]++;
          last_acc[i] = cyc;
        end
      end
      @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        if (nq[i].size() > 0) begin
          vld[i] = 1'b1;
          nib[i] = nq[i][0];
        end else begin
          vld[i] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int inst, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx[inst] === 1'b0) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk($sformatf("i%0d start bit seen", inst), 32'(seen), 32'd1);
  endtask

  // Checks every cycle of one frame starting at the first cycle of its start bit.
  task automatic expect_frame(input int inst, input logic [7:0] d, input bit has_par,
                              input bit par, input int nstop, input int cpb);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (has_par) bits.push_back(par);
    for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int c = 0; c < cpb; c++) begin
        chk($sformatf("i%0d byte %02h bit%0d c%0d tx", inst, d, b, c), 32'(tx[inst]), 32'(bits[b]));
        chk($sformatf("i%0d byte %02h bit%0d busy", inst, d, b), 32'(busy[inst]), 32'd1);
        step();
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] full_bytes [6];
    bit         all_high;
    full_bytes = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};

    // Reset values
    #22;
    chk("rst tx", 32'(tx[0]), 32'd1);
    chk("rst busy", 32'(busy[0]), 32'd0);
    chk("rst level", 32'(lvl[0]), 32'd0);
    chk("rst acp", 32'(acp[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 8N1 byte 0xA5 at 4 clocks per bit
    n_acc[0] = 0;
    nq[0].push_back(4'h5);
    nq[0].push_back(4'hA);
    for (int i = 0; i < 20; i++) begin
      step();
      if (n_acc[0] >= 2) break;
    end
    chk("8n1 both nibbles taken", 32'(n_acc[0]), 32'd2);
    chk("8n1 level after push", 32'(lvl[0]), 32'd1);
    chk("8n1 line idle before start", 32'(tx[0]), 32'd1);
    step();
    chk("8n1 start delay", 32'(cyc - last_acc[0]), 32'd2);
    expect_frame(0, 8'hA5, 1'b0, 1'b0, 1, 4);
    chk("8n1 busy after", 32'(busy[0]), 32'd0);
    chk("8n1 tx after", 32'(tx[0]), 32'd1);

    // Held half byte
    nq[0].push_back(4'h3);
    all_high = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx[0] !== 1'b1 || lvl[0] !== 3'd0) all_high = 1'b0;
    end
    chk("half no frame/level", 32'(all_high), 32'd1);
    chk("half level", 32'(lvl[0]), 32'd0);
    nq[0].push_back(4'hC);
    wait_start(0, 20);
    chk("half start delay", 32'(cyc - last_acc[0]), 32'd2);
    expect_frame(0, 8'hC3, 1'b0, 1'b0, 1, 4);
    chk("half level after", 32'(lvl[0]), 32'd0);

    // FIFO full with 12 nibbles held valid
    n_acc[0] = 0;
    foreach (full_bytes[k]) begin
      nq[0].push_back(full_bytes[k][3:0]);
      nq[0].push_back(full_bytes[k][7:4]);
    end
    fork
      begin
        wait_start(0, 20);
        for (int k = 0; k < 6; k++) expect_frame(0, full_bytes[k], 1'b0, 1'b0, 1, 4);
      end
      begin
        for (int i = 0; i < 60; i++) begin
          if (lvl[0] == 3'd4) break;
          step();
        end
        chk("full level reaches 4", 32'(lvl[0]), 32'd4);
        chk("full acp low", 32'(acp[0]), 32'd0);
        chk("full nibbles taken", 32'(n_acc[0]), 32'd10);
        for (int i = 0; i < 100; i++) begin
          if (acp[0] == 1'b1) break;
          step();
        end
        chk("full acp rises", 32'(acp[0]), 32'd1);
        chk("full level after pop", 32'(lvl[0]), 32'd3);
      end
    join
    chk("full all nibbles taken", 32'(n_acc[0]), 32'd12);
    chk("full busy after", 32'(busy[0]), 32'd0);

    // Two stop bits, even parity, back-to-back 0x00 then 0xFF
    nq[1].push_back(4'h0); nq[1].push_back(4'h0);
    nq[1].push_back(4'hF); nq[1].push_back(4'hF);
    wait_start(1, 20);
    expect_frame(1, 8'h00, 1'b1, 1'b0, 2, 1);
    expect_frame(1, 8'hFF, 1'b1, 1'b0, 2, 1);
    chk("2stop busy after", 32'(busy[1]), 32'd0);
    chk("2stop tx after", 32'(tx[1]), 32'd1);

    // Parity on 0x07: even -> 1, odd -> 0
    nq[1].push_back(4'h7); nq[1].push_back(4'h0);
    wait_start(1, 20);
    expect_frame(1, 8'h07, 1'b1, 1'b1, 2, 1);
    nq[2].push_back(4'h7); nq[2].push_back(4'h0);
    wait_start(2, 20);
    expect_frame(2, 8'h07, 1'b1, 1'b0, 1, 1);
    chk("odd 11-bit frame then idle", 32'(busy[2]), 32'd0);

    // Reset during D3 of 0xA5 with two bytes queued
    nq[0].push_back(4'h5); nq[0].push_back(4'hA);
    nq[0].push_back(4'h1); nq[0].push_back(4'h1);
    nq[0].push_back(4'h2); nq[0].push_back(4'h2);
    wait_start(0, 20);
    repeat (17) step();
    chk("rstmid tx in D3", 32'(tx[0]), 32'd0);
    chk("rstmid level queued", 32'(lvl[0]), 32'd2);
    #2;
    rst_n = 1'b0;
    nq[0].delete();
    #1;
    chk("rstmid tx async", 32'(tx[0]), 32'd1);
    chk("rstmid level async", 32'(lvl[0]), 32'd0);
    chk("rstmid busy async", 32'(busy[0]), 32'd0);
    chk("rstmid acp async", 32'(acp[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    all_high = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tx[0] !== 1'b1) all_high = 1'b0;
    end
    chk("rstmid no frame after", 32'(all_high), 32'd1);
    chk("rstmid level after", 32'(lvl[0]), 32'd0);
    chk("rstmid busy after", 32'(busy[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
